rectangle_ks_ctrl: RTL and testbench
====================================

Name: rectangle_ks_ctrl

Overview:
- Round sequencer for the round-based RECTANGLE-128 core.
- Drives the select of the 128-bit key-state register: 0 loads the master key, 1 feeds back the updated key.
- Generates the 5-bit round constant (RC) and round index for the key-update and round datapaths.
- Provides a start/busy/done handshake to the top level.

Parameters:
- ROUNDS, 25, number of cipher rounds (RUN cycles); legal range 1..31.
- RC_INIT, 5'h01, RC value presented in round 0.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request to start one encryption; sampled only in IDLE.
- o_select  out  1  key-register select: 0 = master key, 1 = updated key.
- o_load  out  1  data-state register loads plaintext (LOAD state only).
- o_round_en  out  1  data-state register takes the round-function output (RUN state).
- ov_round  out  5  current round index, 0..ROUNDS-1.
- ov_rc  out  5  round constant for the key update in the current round.
- o_last  out  1  high in the final RUN cycle (ov_round == ROUNDS-1).
- o_busy  out  1  high in LOAD and RUN.
- o_done  out  1  one-cycle pulse; the key register holds the final whitening key and the data register holds the last-round state.

Behaviour:
- Reset values (async, i_rst_n = 0): state IDLE; ov_round = 0; ov_rc = RC_INIT; o_select, o_load, o_round_en, o_last, o_busy and o_done all 0.
- Outputs are registered or decoded from the state register only; no combinational path from i_start to any output.
- State transitions:
  - IDLE: o_select = 0, so the key register tracks the master key. i_start = 1 -> LOAD; otherwise stay.
  - LOAD (1 cycle): o_select = 0, o_load = 1, o_busy = 1. -> RUN with ov_round = 0, ov_rc = RC_INIT.
  - RUN (ROUNDS cycles): o_select = 1, o_round_en = 1, o_busy = 1.
    - Each edge: ov_round += 1 and ov_rc advances.
    - RC update: rc_next = {rc[3:0], rc[4] ^ rc[2]}.
    - When o_last = 1 -> DONE; ov_round and ov_rc return to 0 and RC_INIT on that edge.
  - DONE (1 cycle): o_done = 1, o_select = 1, o_round_en = 0. -> IDLE.
- Key-register hold: the key register has no enable, so in DONE the key register loads one extra update; the top level samples the whitening key on the o_last edge.
- Latency: i_start sampled at edge E0 -> o_load during cycle E0..E1 -> RUN during E1..E(ROUNDS+1) -> o_done high for the cycle following edge E(ROUNDS+1).
- RC sequence for ROUNDS = 25: 01,02,04,09,12,05,0B,16,0C,19,13,07,0F,1F,1E,1C,18,11,03,06,0D,1B,17,0E,1D.
- Boundary conditions:
  - i_start is ignored in LOAD, RUN and DONE; it is not queued.
  - i_start held high continuously gives back-to-back operations with one IDLE cycle between o_done and the next o_load.
  - Reset asserted mid-operation forces all reset values immediately; no o_done is issued.
  - ov_round never wraps past ROUNDS-1.
  - ROUNDS = 1: a single RUN cycle with o_last = 1.

Optional Feature:
- Macro: RECTANGLE_CTRL_ABORT_EN.
- Defined:
  - Adds input port i_abort (1 bit).
  - i_abort = 1 in LOAD or RUN returns the FSM to IDLE on the next edge with ov_round = 0 and ov_rc = RC_INIT; no o_done is issued.
  - i_abort has priority over RUN -> DONE when o_last = 1.
  - i_abort in IDLE or DONE has no effect.
- Undefined: the port is absent and every operation runs to completion.

Test Plan:
- Reset, then i_start pulse with ROUNDS = 25:
  - o_load high exactly 1 cycle after the start edge, with o_select = 0.
  - 25 RUN cycles follow with o_select = 1; o_done pulses 27 cycles after the start edge.
- RC check over one operation: ov_rc steps 01,02,04,09,...,0E,1D; o_last = 1 only when ov_round = 24 and ov_rc = 1D.
- i_start held high for 60 cycles:
  - Two complete operations.
  - Exactly one IDLE cycle between the first o_done and the second o_load.
  - Extra i_start during RUN is ignored.
- i_rst_n driven low asynchronously at ov_round = 10: outputs return to reset values before the next clock edge; no o_done afterwards.
- With RECTANGLE_CTRL_ABORT_EN defined:
  - i_abort at ov_round = 5 -> IDLE next cycle, ov_rc = 01, no o_done.
  - A subsequent i_start completes normally.
- ROUNDS = 1 build: i_start -> LOAD -> one RUN cycle (o_last = 1, ov_rc = 01) -> o_done.

Source files
------------

// File: rtl/rectangle_ks_ctrl.sv
// rectangle_ks_ctrl: round sequencer for the round-based RECTANGLE-128 core.
// Steers the key-state register select, hands out the round index and the
// 5-bit round constant, and runs a start/busy/done handshake.
// Optional build macro: RECTANGLE_CTRL_ABORT_EN adds the i_abort input, which
// drops an operation in LOAD or RUN straight back to IDLE.
//
// state | meaning
// IDLE  | waiting for i_start; key register tracks the master key
// LOAD  | data register loads plaintext; key register still on master key
// RUN   | one round per cycle; key register takes the updated key
// DONE  | one-cycle o_done pulse; results are held by the top level
module rectangle_ks_ctrl #(
    parameter int         ROUNDS  = 25,
    parameter logic [4:0] RC_INIT = 5'h01
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
`ifdef RECTANGLE_CTRL_ABORT_EN
    input  logic       i_abort,
`endif
    input  logic       i_start,
    output logic       o_select,
    output logic       o_load,
    output logic       o_round_en,
    output logic [4:0] ov_round,
    output logic [4:0] ov_rc,
    output logic       o_last,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] round_q, round_d;
    logic [4:0] rc_q, rc_d;
    logic       abort_req;
    logic       last_round;

`ifdef RECTANGLE_CTRL_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_round = (state_q == RUN) && (round_q == LAST_ROUND);

    // State, round index and round constant registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            round_q <= 5'd0;
            rc_q    <= RC_INIT;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rc_q    <= rc_d;
        end
    end

    // Next-state logic; abort overrides every LOAD/RUN transition, including
    // the final RUN -> DONE step.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rc_d    = rc_q;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = LOAD;
            end
            LOAD: begin
                state_d = RUN;
                round_d = 5'd0;
                rc_d    = RC_INIT;
            end
            RUN: begin
                if (last_round) begin
                    state_d = DONE;
                    round_d = 5'd0;
                    rc_d    = RC_INIT;
                end else begin
                    round_d = round_q + 5'd1;
                    rc_d    = {rc_q[3:0], rc_q[4] ^ rc_q[2]};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                round_d = 5'd0;
                rc_d    = RC_INIT;
            end
        endcase
        if (abort_req && ((state_q == LOAD) || (state_q == RUN))) begin
            state_d = IDLE;
            round_d = 5'd0;
            rc_d    = RC_INIT;
        end
    end

    // Outputs are pure decodes of the registers, so i_start never reaches them.
    always_comb begin
        o_select   = (state_q == RUN) || (state_q == DONE);
        o_load     = (state_q == LOAD);
        o_round_en = (state_q == RUN);
        o_busy     = (state_q == LOAD) || (state_q == RUN);
        o_done     = (state_q == DONE);
        o_last     = last_round;
        ov_round   = round_q;
        ov_rc      = rc_q;
    end

endmodule

// File: tb/tb_rectangle_ks_ctrl.sv
// tb_rectangle_ks_ctrl: drives two controllers (ROUNDS = 25 and ROUNDS = 1)
// from the same inputs and compares them every cycle against an operation-level
// reference model: "cycles since start" of the current operation.
// Build with RECTANGLE_CTRL_ABORT_EN defined to exercise the abort input.
module tb_rectangle_ks_ctrl;

    localparam int         ROUNDS  = 25;
    localparam logic [4:0] RC_INIT = 5'h01;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_start = 1'b0;
    logic i_abort = 1'b0;

    logic [1:0] sel, load, ren, last, busy, done;
    logic [4:0] rnd [2];
    logic [4:0] rc  [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] spec_rc [25] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B,
                                 5'h16, 5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F,
                                 5'h1E, 5'h1C, 5'h18, 5'h11, 5'h03, 5'h06, 5'h0D,
                                 5'h1B, 5'h17, 5'h0E, 5'h1D};

    always #5 i_clk = ~i_clk;

    rectangle_ks_ctrl #(.ROUNDS(ROUNDS), .RC_INIT(RC_INIT)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
`ifdef RECTANGLE_CTRL_ABORT_EN
        .i_abort    (i_abort),
`endif
        .i_start    (i_start),
        .o_select   (sel[0]),
        .o_load     (load[0]),
        .o_round_en (ren[0]),
        .ov_round   (rnd[0]),
        .ov_rc      (rc[0]),
        .o_last     (last[0]),
        .o_busy     (busy[0]),
        .o_done     (done[0])
    );

    rectangle_ks_ctrl #(.ROUNDS(1), .RC_INIT(RC_INIT)) dut_r1 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
`ifdef RECTANGLE_CTRL_ABORT_EN
        .i_abort    (i_abort),
`endif
        .i_start    (i_start),
        .o_select   (sel[1]),
        .o_load     (load[1]),
        .o_round_en (ren[1]),
        .ov_round   (rnd[1]),
        .ov_rc      (rc[1]),
        .o_last     (last[1]),
        .o_busy     (busy[1]),
        .o_done     (done[1])
    );

    // Reference model: an operation is active for ROUNDS+2 cycles counted by m_t
    // (0 = load, 1..R = rounds, R+1 = done); it can only begin while inactive.
    bit m_act [2] = '{1'b0, 1'b0};
    int m_t   [2] = '{0, 0};
    int m_r   [2] = '{ROUNDS, 1};

    function automatic logic [4:0] rc_at(int n);
        logic [4:0] r;
        r = RC_INIT;
        for (int i = 0; i < n; i++) r = {r[3:0], r[4] ^ r[2]};
        return r;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!i_rst_n) begin
                m_act[k] = 1'b0;
                m_t[k]   = 0;
            end else if (!m_act[k]) begin
                if (i_start) begin
                    m_act[k] = 1'b1;
                    m_t[k]   = 0;
                end
`ifdef RECTANGLE_CTRL_ABORT_EN
            end else if (i_abort && m_t[k] <= m_r[k]) begin
                m_act[k] = 1'b0;
`endif
            end else begin
                m_t[k] = m_t[k] + 1;
                if (m_t[k] > m_r[k] + 1) m_act[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input int k);
        logic e_sel, e_load, e_ren, e_last, e_busy, e_done;
        logic [4:0] e_rnd, e_rc;
        int t, r;
        e_sel = 0; e_load = 0; e_ren = 0; e_last = 0; e_busy = 0; e_done = 0;
        e_rnd = 5'd0; e_rc = RC_INIT;
        t = m_t[k];
        r = m_r[k];
        if (m_act[k]) begin
            if (t == 0) begin
                e_load = 1; e_busy = 1;
            end else if (t <= r) begin
                e_sel = 1; e_ren = 1; e_busy = 1;
                e_rnd = 5'(t - 1);
                e_rc  = rc_at(t - 1);
                e_last = (t == r);
            end else begin
                e_sel = 1; e_done = 1;
            end
        end
        chk($sformatf("select[%0d]", k),   32'(sel[k]),  32'(e_sel));
        chk($sformatf("load[%0d]", k),     32'(load[k]), 32'(e_load));
        chk($sformatf("round_en[%0d]", k), 32'(ren[k]),  32'(e_ren));
        chk($sformatf("round[%0d]", k),    32'(rnd[k]),  32'(e_rnd));
        chk($sformatf("rc[%0d]", k),       32'(rc[k]),   32'(e_rc));
        chk($sformatf("last[%0d]", k),     32'(last[k]), 32'(e_last));
        chk($sformatf("busy[%0d]", k),     32'(busy[k]), 32'(e_busy));
        chk($sformatf("done[%0d]", k),     32'(done[k]), 32'(e_done));
    endtask

    task automatic tick(input logic s, input logic a);
        @(negedge i_clk);
        check_dut(0);
        check_dut(1);
        if (ren[0] && rnd[0] < 5'd25) begin
            chk("rc_table", 32'(rc[0]), 32'(spec_rc[rnd[0]]));
            chk("last_only_at_24", 32'(last[0]), 32'(rnd[0] == 5'd24));
        end
        i_start = s;
        i_abort = a;
    endtask

    task automatic wait_round(input int r);
        bit found;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(1'b0, 1'b0);
            if (ren[0] && rnd[0] == 5'(r)) found = 1;
        end
        chk("wait_round_reached", 32'(found), 32'd1);
    endtask

    int n_lat;
    int n_done;
    int n_load;
    int gap;

    initial begin
        // reset
        repeat (3) tick(1'b0, 1'b0);
        i_rst_n = 1'b1;
        repeat (2) tick(1'b0, 1'b0);

        // single start pulse, latency to o_done
        tick(1'b1, 1'b0);
        n_lat = 0;
        for (int i = 0; i < 60 && !done[0]; i++) begin
            tick(1'b0, 1'b0);
            n_lat++;
        end
        chk("done_latency", 32'(n_lat), 32'(ROUNDS + 2));
        repeat (3) tick(1'b0, 1'b0);

        // start held high: back-to-back operations with one idle cycle
        n_done = 0; n_load = 0; gap = -1;
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, 1'b0);
            if (done[0]) begin
                n_done++;
                gap = 0;
            end else if (gap >= 0 && !load[0]) begin
                gap++;
            end else if (gap >= 0 && load[0]) begin
                chk("idle_gap", 32'(gap), 32'd1);
                gap = -1;
            end
            if (load[0]) n_load++;
        end
        chk("held_start_dones", 32'(n_done), 32'd2);
        chk("held_start_loads", 32'(n_load), 32'd3);
        tick(1'b0, 1'b0);
        repeat (30) tick(1'b0, 1'b0);

        // async reset at round 10
        tick(1'b1, 1'b0);
        wait_round(10);
        i_start = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_round", 32'(rnd[0]), 32'd0);
        chk("async_rst_rc", 32'(rc[0]), 32'(RC_INIT));
        chk("async_rst_busy", 32'(busy[0]), 32'd0);
        chk("async_rst_select", 32'(sel[0]), 32'd0);
        repeat (2) tick(1'b0, 1'b0);
        i_rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0);
            if (done[0]) n_done++;
        end
        chk("no_done_after_reset", 32'(n_done), 32'd0);

`ifdef RECTANGLE_CTRL_ABORT_EN
        // abort at round 5, then a normal operation
        tick(1'b1, 1'b0);
        wait_round(5);
        i_abort = 1'b1;
        tick(1'b0, 1'b0);
        chk("abort_idle", 32'(busy[0]), 32'd0);
        chk("abort_rc", 32'(rc[0]), 32'(RC_INIT));
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            if (done[0]) n_done++;
        end
        chk("no_done_after_abort", 32'(n_done), 32'd0);
        tick(1'b1, 1'b0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0);
            if (done[0]) n_done++;
        end
        chk("done_after_abort_restart", 32'(n_done), 32'd1);
`endif

        // randomized start (and abort) traffic
        for (int i = 0; i < 400; i++) begin
`ifdef RECTANGLE_CTRL_ABORT_EN
            tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
`else
            tick(1'($urandom_range(0, 3) == 0), 1'b0);
`endif
        end
        repeat (2) tick(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
